// File: rtl/pic_cmd_regfile.sv
// 8259 command register file: tracks the ICW1..ICW4 initialization sequence,
// holds OCW state (mask, read select, special mask) and serves status reads.
module pic_cmd_regfile (
    input  logic       clk,
    input  logic       rst,
    input  logic       wr_valid,
    input  logic       cmd_type,
    input  logic [1:0] cmd_nr,
    input  logic [7:0] cmd_data,
    input  logic       rd_req,
    input  logic       rd_a0,
    input  logic [7:0] irr_in,
    input  logic [7:0] isr_in,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic [7:0] imr,
    output logic       init_done,
    output logic       ltim,
    output logic       single,
    output logic [4:0] vector_base,
    output logic [7:0] cascade_cfg,
    output logic       aeoi,
    output logic       sfnm,
    output logic       ocw2_valid,
    output logic [2:0] ocw2_cmd,
    output logic [2:0] ocw2_level,
    output logic       read_isr,
    output logic       smm,
    output logic       poll_req,
    output logic       seq_error
);

    typedef enum logic [2:0] {
        ST_UNINIT    = 3'd0,
        ST_WAIT_ICW2 = 3'd1,
        ST_WAIT_ICW3 = 3'd2,
        ST_WAIT_ICW4 = 3'd3,
        ST_READY     = 3'd4
    } state_t;

    state_t     state_q;
    logic       ic4_q;
    logic [7:0] rd_data_q;
    logic       rd_valid_q;
    logic [7:0] imr_q;
    logic       init_done_q;
    logic       ltim_q;
    logic       single_q;
    logic [4:0] vector_base_q;
    logic [7:0] cascade_cfg_q;
    logic       aeoi_q;
    logic       sfnm_q;
    logic       ocw2_valid_q;
    logic [2:0] ocw2_cmd_q;
    logic [2:0] ocw2_level_q;
    logic       read_isr_q;
    logic       smm_q;
    logic       poll_req_q;
    logic       seq_error_q;

    logic       icw1_s;
    logic       icw2_s;
    logic       icw3_s;
    logic       icw4_s;
    logic       ocw_ok_s;
    logic       bad_s;
    logic [7:0] rd_sel_s;

    // Classify the incoming write against the current sequencer state.
    always_comb begin
        icw1_s   = wr_valid && cmd_type && (cmd_nr == 2'd0);
        icw2_s   = wr_valid && cmd_type && (cmd_nr == 2'd1) && (state_q == ST_WAIT_ICW2);
        icw3_s   = wr_valid && cmd_type && (cmd_nr == 2'd2) && (state_q == ST_WAIT_ICW3);
        icw4_s   = wr_valid && cmd_type && (cmd_nr == 2'd3) && (state_q == ST_WAIT_ICW4);
        ocw_ok_s = wr_valid && !cmd_type && (state_q == ST_READY) && (cmd_nr != 2'd3);
        bad_s    = wr_valid && !(icw1_s || icw2_s || icw3_s || icw4_s || ocw_ok_s);
    end

    // Read mux uses pre-write register values, so a same-cycle write is not visible.
    always_comb begin
        rd_sel_s = 8'h00;
        if (rd_a0) begin
            rd_sel_s = imr_q;
        end else if (read_isr_q) begin
            rd_sel_s = isr_in;
        end else begin
            rd_sel_s = irr_in;
        end
    end

    // Sequencer, architectural registers, command pulses and read port.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= ST_UNINIT;
            ic4_q         <= 1'b0;
            rd_data_q     <= 8'h00;
            rd_valid_q    <= 1'b0;
            imr_q         <= 8'h00;
            init_done_q   <= 1'b0;
            ltim_q        <= 1'b0;
            single_q      <= 1'b0;
            vector_base_q <= 5'd0;
            cascade_cfg_q <= 8'h00;
            aeoi_q        <= 1'b0;
            sfnm_q        <= 1'b0;
            ocw2_valid_q  <= 1'b0;
            ocw2_cmd_q    <= 3'd0;
            ocw2_level_q  <= 3'd0;
            read_isr_q    <= 1'b0;
            smm_q         <= 1'b0;
            poll_req_q    <= 1'b0;
            seq_error_q   <= 1'b0;
        end else begin
            ocw2_valid_q <= 1'b0;
            poll_req_q   <= 1'b0;
            rd_valid_q   <= rd_req;
            if (rd_req) begin
                rd_data_q <= rd_sel_s;
            end

            if (icw1_s) begin
                ltim_q        <= cmd_data[3];
                single_q      <= cmd_data[1];
                ic4_q         <= cmd_data[0];
                imr_q         <= 8'h00;
                read_isr_q    <= 1'b0;
                smm_q         <= 1'b0;
                aeoi_q        <= 1'b0;
                sfnm_q        <= 1'b0;
                cascade_cfg_q <= 8'h00;
                seq_error_q   <= 1'b0;
                init_done_q   <= 1'b0;
                state_q       <= ST_WAIT_ICW2;
            end else if (icw2_s) begin
                vector_base_q <= cmd_data[7:3];
                if (!single_q) begin
                    state_q <= ST_WAIT_ICW3;
                end else if (ic4_q) begin
                    state_q <= ST_WAIT_ICW4;
                end else begin
                    state_q     <= ST_READY;
                    init_done_q <= 1'b1;
                end
            end else if (icw3_s) begin
                cascade_cfg_q <= cmd_data;
                if (ic4_q) begin
                    state_q <= ST_WAIT_ICW4;
                end else begin
                    state_q     <= ST_READY;
                    init_done_q <= 1'b1;
                end
            end else if (icw4_s) begin
                aeoi_q      <= cmd_data[1];
                sfnm_q      <= cmd_data[4];
                state_q     <= ST_READY;
                init_done_q <= 1'b1;
            end else if (ocw_ok_s) begin
                case (cmd_nr)
                    2'd0: imr_q <= cmd_data;
                    2'd1: begin
                        ocw2_valid_q <= 1'b1;
                        ocw2_cmd_q   <= cmd_data[7:5];
                        ocw2_level_q <= cmd_data[2:0];
                    end
                    2'd2: begin
                        if (cmd_data[1]) begin
                            read_isr_q <= cmd_data[0];
                        end
                        if (cmd_data[6]) begin
                            smm_q <= cmd_data[5];
                        end
                        poll_req_q <= cmd_data[2];
                    end
                    default: seq_error_q <= 1'b1;
                endcase
            end else if (bad_s) begin
                seq_error_q <= 1'b1;
            end
        end
    end

    assign rd_data     = rd_data_q;
    assign rd_valid    = rd_valid_q;
    assign imr         = imr_q;
    assign init_done   = init_done_q;
    assign ltim        = ltim_q;
    assign single      = single_q;
    assign vector_base = vector_base_q;
    assign cascade_cfg = cascade_cfg_q;
    assign aeoi        = aeoi_q;
    assign sfnm        = sfnm_q;
    assign ocw2_valid  = ocw2_valid_q;
    assign ocw2_cmd    = ocw2_cmd_q;
    assign ocw2_level  = ocw2_level_q;
    assign read_isr    = read_isr_q;
    assign smm         = smm_q;
    assign poll_req    = poll_req_q;
    assign seq_error   = seq_error_q;

endmodule

// File: tb/tb_pic_cmd_regfile.sv
// Bench for pic_cmd_regfile: hand-checked vector table and directed init
// sequence, then random traffic against a queue-based model of the ICW protocol.
module tb_pic_cmd_regfile;

    logic       clk;
    logic       rst;
    logic       wr_valid;
    logic       cmd_type;
    logic [1:0] cmd_nr;
    logic [7:0] cmd_data;
    logic       rd_req;
    logic       rd_a0;
    logic [7:0] irr_in;
    logic [7:0] isr_in;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic [7:0] imr;
    logic       init_done;
    logic       ltim;
    logic       single;
    logic [4:0] vector_base;
    logic [7:0] cascade_cfg;
    logic       aeoi;
    logic       sfnm;
    logic       ocw2_valid;
    logic [2:0] ocw2_cmd;
    logic [2:0] ocw2_level;
    logic       read_isr;
    logic       smm;
    logic       poll_req;
    logic       seq_error;

    pic_cmd_regfile dut (
        .clk(clk), .rst(rst), .wr_valid(wr_valid), .cmd_type(cmd_type),
        .cmd_nr(cmd_nr), .cmd_data(cmd_data), .rd_req(rd_req), .rd_a0(rd_a0),
        .irr_in(irr_in), .isr_in(isr_in), .rd_data(rd_data), .rd_valid(rd_valid),
        .imr(imr), .init_done(init_done), .ltim(ltim), .single(single),
        .vector_base(vector_base), .cascade_cfg(cascade_cfg), .aeoi(aeoi),
        .sfnm(sfnm), .ocw2_valid(ocw2_valid), .ocw2_cmd(ocw2_cmd),
        .ocw2_level(ocw2_level), .read_isr(read_isr), .smm(smm),
        .poll_req(poll_req), .seq_error(seq_error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_total = 0;
    int n_pass  = 0;

    // Reference model: pending ICW words are kept as a queue of word numbers (2..4).
    int         m_pend[$];
    logic       m_started;
    logic [7:0] m_rdd, m_imr, m_cas;
    logic       m_rdv, m_ltim, m_single, m_ic4, m_aeoi, m_sfnm;
    logic       m_o2v, m_risr, m_smm, m_poll, m_serr;
    logic [4:0] m_vb;
    logic [2:0] m_o2c, m_o2l;

    function automatic logic m_ready();
        return m_started && (m_pend.size() == 0);
    endfunction

    task automatic model_step();
        int n;
        if (rst) begin
            m_pend.delete();
            m_started = 1'b0; m_rdd = 8'h00; m_imr = 8'h00; m_cas = 8'h00;
            m_rdv = 1'b0; m_ltim = 1'b0; m_single = 1'b0; m_ic4 = 1'b0;
            m_aeoi = 1'b0; m_sfnm = 1'b0; m_o2v = 1'b0; m_risr = 1'b0;
            m_smm = 1'b0; m_poll = 1'b0; m_serr = 1'b0; m_vb = 5'd0;
            m_o2c = 3'd0; m_o2l = 3'd0;
        end else begin
            m_rdv = rd_req;
            if (rd_req) m_rdd = rd_a0 ? m_imr : (m_risr ? isr_in : irr_in);
            m_o2v = 1'b0;
            m_poll = 1'b0;
            if (wr_valid) begin
                if (cmd_type && cmd_nr == 2'd0) begin
                    m_ltim = cmd_data[3]; m_single = cmd_data[1]; m_ic4 = cmd_data[0];
                    m_imr = 8'h00; m_risr = 1'b0; m_smm = 1'b0; m_aeoi = 1'b0;
                    m_sfnm = 1'b0; m_cas = 8'h00; m_serr = 1'b0; m_started = 1'b1;
                    m_pend.delete();
                    m_pend.push_back(2);
                    if (!cmd_data[1]) m_pend.push_back(3);
                    if (cmd_data[0]) m_pend.push_back(4);
                end else if (cmd_type) begin
                    n = int'(cmd_nr) + 1;
                    if (m_pend.size() > 0 && m_pend[0] == n) begin
                        void'(m_pend.pop_front());
                        if (n == 2) m_vb = cmd_data[7:3];
                        else if (n == 3) m_cas = cmd_data;
                        else begin m_aeoi = cmd_data[1]; m_sfnm = cmd_data[4]; end
                    end else m_serr = 1'b1;
                end else if (m_ready() && cmd_nr != 2'd3) begin
                    if (cmd_nr == 2'd0) m_imr = cmd_data;
                    else if (cmd_nr == 2'd1) begin
                        m_o2v = 1'b1; m_o2c = cmd_data[7:5]; m_o2l = cmd_data[2:0];
                    end else begin
                        if (cmd_data[1]) m_risr = cmd_data[0];
                        if (cmd_data[6]) m_smm = cmd_data[5];
                        m_poll = cmd_data[2];
                    end
                end else m_serr = 1'b1;
            end
        end
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else n_pass++;
    endtask

    task automatic tick();
        logic [45:0] dv, mv;
        model_step();
        @(posedge clk);
        #1;
        dv = {rd_data, rd_valid, imr, init_done, ltim, single, vector_base, cascade_cfg,
              aeoi, sfnm, ocw2_valid, ocw2_cmd, ocw2_level, read_isr, smm, poll_req, seq_error};
        mv = {m_rdd, m_rdv, m_imr, m_ready(), m_ltim, m_single, m_vb, m_cas,
              m_aeoi, m_sfnm, m_o2v, m_o2c, m_o2l, m_risr, m_smm, m_poll, m_serr};
        chk("model", 64'(dv), 64'(mv));
    endtask

    task automatic drive(input logic r, input logic w, input logic t, input logic [1:0] nr,
                         input logic [7:0] d, input logic rq, input logic a0);
        rst = r; wr_valid = w; cmd_type = t; cmd_nr = nr; cmd_data = d; rd_req = rq; rd_a0 = a0;
    endtask

    typedef struct {
        logic r, w, t; logic [1:0] nr; logic [7:0] d; logic rq, a0;
        logic e_init, e_serr; logic [7:0] e_imr; logic e_rdv; logic [7:0] e_rdd;
        logic e_o2v, e_poll;
    } vec_t;

    function automatic vec_t mk(logic r, logic w, logic t, logic [1:0] nr, logic [7:0] d,
                                logic rq, logic a0, logic ei, logic es, logic [7:0] em,
                                logic erv, logic [7:0] erd, logic eo, logic ep);
        vec_t v;
        v.r = r; v.w = w; v.t = t; v.nr = nr; v.d = d; v.rq = rq; v.a0 = a0;
        v.e_init = ei; v.e_serr = es; v.e_imr = em; v.e_rdv = erv; v.e_rdd = erd;
        v.e_o2v = eo; v.e_poll = ep;
        return v;
    endfunction

    vec_t tbl[$];

    initial begin
        drive(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0);
        irr_in = 8'h0F;
        isr_in = 8'h80;
        @(negedge clk);
        tick();
        tick();

        // Directed full init (cascaded, ICW4 present).
        drive(1'b0, 1'b1, 1'b1, 2'd0, 8'h11, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b1, 1'b1, 2'd1, 8'h48, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b1, 1'b1, 2'd2, 8'h04, 1'b0, 1'b0); tick();
        chk("init_before_icw4", 64'(init_done), 64'd0);
        drive(1'b0, 1'b1, 1'b1, 2'd3, 8'h02, 1'b0, 1'b0); tick();
        chk("init_done", 64'(init_done), 64'd1);
        chk("vector_base", 64'(vector_base), 64'h09);
        chk("cascade_cfg", 64'(cascade_cfg), 64'h04);
        chk("aeoi", 64'(aeoi), 64'd1);
        chk("seq_error", 64'(seq_error), 64'd0);
        drive(1'b0, 1'b1, 1'b0, 2'd1, 8'h63, 1'b0, 1'b0); tick();
        chk("ocw2_pulse", 64'({ocw2_valid, ocw2_cmd, ocw2_level}), 64'({1'b1, 3'b011, 3'd3}));
        drive(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0); tick();
        chk("ocw2_drop", 64'(ocw2_valid), 64'd0);

        //           r     w     t     nr    d      rq    a0    init  serr  imr    rdv   rdd    o2v   poll
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 2'd0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 2'd1, 8'h48, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 2'd2, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 2'd3, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 2'd0, 8'h13, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 2'd1, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 2'd3, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 2'd0, 8'hA5, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'hA5, 1'b1, 8'hA5, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 8'hA5, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 8'h0F, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 2'd2, 8'h0B, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 8'h0F, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 8'h80, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 2'd2, 8'h0C, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 8'h80, 1'b0, 1'b1));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b1, 8'h80, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 2'd1, 8'h63, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 8'h80, 1'b1, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1'b0, 8'h80, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 2'd0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 1'b0, 8'h80, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 2'd0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h80, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 2'd0, 8'h55, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 2'd0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 2'd2, 8'h04, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 2'd1, 8'h48, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 2'd1, 8'h48, 1'b0, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 2'd0, 8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 2'd1, 8'h08, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b1, 2'd3, 8'h02, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 2'd0, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 8'h00, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b0, 1'b0, 2'd0, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 8'h3C, 1'b1, 8'h3C, 1'b0, 1'b0));
        tbl.push_back(mk(1'b0, 1'b1, 1'b0, 2'd3, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b1, 8'h3C, 1'b0, 8'h3C, 1'b0, 1'b0));

        foreach (tbl[i]) begin
            drive(tbl[i].r, tbl[i].w, tbl[i].t, tbl[i].nr, tbl[i].d, tbl[i].rq, tbl[i].a0);
            tick();
            chk($sformatf("vec%0d", i),
                64'({init_done, seq_error, imr, rd_valid, rd_data, ocw2_valid, poll_req}),
                64'({tbl[i].e_init, tbl[i].e_serr, tbl[i].e_imr, tbl[i].e_rdv,
                     tbl[i].e_rdd, tbl[i].e_o2v, tbl[i].e_poll}));
        end

        // Random traffic, biased toward the next legal ICW so READY is reached often.
        for (int k = 0; k < 1500; k++) begin
            logic       w, t;
            logic [1:0] nr;
            w = 1'($urandom_range(0, 1));
            t = 1'($urandom_range(0, 1));
            nr = 2'($urandom_range(0, 3));
            if (w && m_pend.size() > 0 && $urandom_range(0, 2) == 0) begin
                t = 1'b1;
                nr = 2'(m_pend[0] - 1);
            end
            irr_in = 8'($urandom);
            isr_in = 8'($urandom);
            drive(1'($urandom_range(0, 96) == 0), w, t, nr, 8'($urandom),
                  1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            tick();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
